// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/grant/rvalid bus between the MEM-stage LSU and memory.
// The master modport is the LSU side; the slave modport is the memory side.
interface mem_stage_lsu_if #(
    parameter int XLEN = 64
);
    logic              req;
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [XLEN/8-1:0] wstrb;
    logic [XLEN-1:0]   wdata;
    logic              gnt;
    logic              rvalid;
    logic [XLEN-1:0]   rdata;

    modport master (
        output req, we, addr, wstrb, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wstrb, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: aligned byte-lane bus access, load extension, pipeline stall.
// Optional bus watchdog is enabled by defining LSU_TIMEOUT_EN.
module mem_stage_lsu #(
    parameter int XLEN           = 64,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        mem_m,
    input  logic [XLEN-1:0]   mem_addr,
    input  logic [XLEN-1:0]   mem_wdata,
    input  logic [31:0]       mem_inst,
    mem_stage_lsu_if.master   dmem,
    output logic              lsu_stall,
    output logic [XLEN-1:0]   load_data,
    output logic              misaligned,
    output logic              bus_error
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   load_q, load_d;
    logic [7:0]        strb_q, strb_d;
    logic [2:0]        off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              mis_q, mis_d;
    logic              err_q, err_d;

    logic              op;
    logic              is_st;
    logic [2:0]        off_in;
    logic [1:0]        size_in;
    logic [7:0]        strb_base;
    logic              mis_in;
    logic              tmo;

    logic unused_ok;
    assign unused_ok = ^{mem_m[0], mem_inst[31:15], mem_inst[11:0]};

    function automatic logic [XLEN-1:0] extend(
        input logic [XLEN-1:0] rd,
        input logic [2:0]      o,
        input logic [1:0]      s,
        input logic            u
    );
        logic [XLEN-1:0] sh;
        sh = rd >> {o, 3'b000};
        unique case (s)
            2'd0: extend = u ? {56'b0, sh[7:0]}
                             : {{56{sh[7]}}, sh[7:0]};
            2'd1: extend = u ? {48'b0, sh[15:0]}
                             : {{48{sh[15]}}, sh[15:0]};
            2'd2: extend = u ? {32'b0, sh[31:0]}
                             : {{32{sh[31]}}, sh[31:0]};
            2'd3: extend = sh;
        endcase
    endfunction

    // Decode of the EX/MEM bundle; a read+write combination is a store
    always_comb begin
        op      = mem_m[1] | mem_m[2];
        is_st   = mem_m[2];
        off_in  = mem_addr[2:0];
        size_in = mem_inst[13:12];
        unique case (size_in)
            2'd0: begin strb_base = 8'h01; mis_in = 1'b0;          end
            2'd1: begin strb_base = 8'h03; mis_in = off_in[0];     end
            2'd2: begin strb_base = 8'h0F; mis_in = |off_in[1:0];  end
            2'd3: begin strb_base = 8'hFF; mis_in = |off_in;       end
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (state_q == REQ || state_q == RESP)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_tmo = TIMEOUT_CYCLES;
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        off_d   = off_q;
        size_d  = size_q;
        uns_d   = uns_q;
        load_d  = load_q;
        mis_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (op && mis_in) begin
                    state_d = DONE;
                    mis_d   = 1'b1;
                    load_d  = '0;
                end else if (op) begin
                    state_d = REQ;
                    we_d    = is_st;
                    addr_d  = {mem_addr[XLEN-1:3], 3'b000};
                    wdata_d = mem_wdata << {off_in, 3'b000};
                    strb_d  = is_st ? (strb_base << off_in) : 8'h00;
                    off_d   = off_in;
                    size_d  = size_in;
                    uns_d   = mem_inst[14];
                end
            end
            REQ: begin
                if (dmem.gnt) begin
                    state_d = RESP;
                end else if (tmo) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    load_d  = '0;
                end
            end
            RESP: begin
                if (dmem.rvalid) begin
                    state_d = DONE;
                    load_d  = we_q ? '0
                                   : extend(dmem.rdata, off_q, size_q, uns_q);
                end else if (tmo) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    load_d  = '0;
                end
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            off_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            load_q  <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            off_q   <= off_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            load_q  <= load_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    // Bus fields come from registers captured on REQ entry, so they hold while req=1
    logic in_req;
    assign in_req     = (state_q == REQ);
    assign dmem.req   = in_req;
    assign dmem.we    = in_req & we_q;
    assign dmem.addr  = in_req ? addr_q  : '0;
    assign dmem.wstrb = in_req ? strb_q  : '0;
    assign dmem.wdata = in_req ? wdata_q : '0;

    assign lsu_stall  = ~rst & (((state_q == IDLE) & op)
                              | (state_q == REQ)
                              | (state_q == RESP));
    assign load_data  = load_q;
    assign misaligned = mis_q;
`ifdef LSU_TIMEOUT_EN
    assign bus_error  = err_q;
`else
    assign bus_error  = 1'b0;
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit in the MEM stage, directly downstream of the EX/MEM pipeline register.
- Consumes the registered MEM control bits, ALU result (effective address), rs2 data and instruction.
- Drives a request/grant/rvalid data-memory bus with byte strobes and produces sign/zero-extended load data for the MEM/WB register.
- Holds the pipeline with a stall signal while an access is outstanding.

Parameters:
- XLEN, 64, data/address width; only 64 is supported.
- TIMEOUT_CYCLES, 16, watchdog limit used only when LSU_TIMEOUT_EN is defined.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  asynchronous active-high reset
- mem_m  input  3  EX/MEM control: [0] branch (ignored here), [1] mem_read, [2] mem_write
- mem_addr  input  64  effective address (EX/MEM ALU result)
- mem_wdata  input  64  store data (EX/MEM rs2 data)
- mem_inst  input  32  instruction; funct3 = [14:12]
- dmem_req  output  1  bus request
- dmem_we  output  1  1 = write
- dmem_addr  output  64  doubleword-aligned address
- dmem_wstrb  output  8  byte strobes
- dmem_wdata  output  64  lane-shifted store data
- dmem_gnt  input  1  request accepted this cycle
- dmem_rvalid  input  1  response/ack valid this cycle
- dmem_rdata  input  64  read data
- lsu_stall  output  1  hold IF/ID/EX and EX/MEM
- load_data  output  64  extended load result, valid in DONE
- misaligned  output  1  one-cycle pulse on a misaligned access
- bus_error  output  1  one-cycle pulse on watchdog abort (0 when the feature is off)

Behaviour:
- op = mem_m[1] | mem_m[2]. If both bits are set, treat as a store.
- States: IDLE, REQ, RESP, DONE.
- IDLE: if op and aligned -> REQ. If op and misaligned -> DONE with misaligned=1 for that cycle and no bus request.
- REQ: dmem_req=1 until dmem_gnt; on gnt -> RESP. Address, we, strobes and wdata stay stable while req=1.
- RESP: wait for dmem_rvalid. On rvalid, capture the extended load (0 for stores) into load_data -> DONE. Stores also complete on rvalid.
- DONE: lsu_stall=0 for one cycle so the pipeline advances; -> IDLE.
- lsu_stall = (IDLE & op) | REQ | RESP. It is combinational and goes high in the same cycle a memory op arrives.
- Latency: a 0-wait bus (gnt in the REQ cycle, rvalid in the next cycle) gives 3 stall cycles and 1 DONE cycle.
- dmem_addr = {addr[63:3], 3'b0}. Byte offset o = addr[2:0].
- Size from funct3[1:0]: 0=B, 1=H, 2=W, 3=D. funct3[2]=1 means zero-extend (LBU/LHU/LWU).
- Strobes: B=1, H=3, W=0xF, D=0xFF, each shifted left by o. dmem_wdata = wdata << 8*o.
- Misaligned when o is not a multiple of the size in bytes: H needs o[0]=0, W needs o[1:0]=0, D needs o=0.
- Load: (rdata >> 8*o), truncated to the size, then sign- or zero-extended to 64 bits.
- dmem_gnt or dmem_rvalid outside the state that expects it: ignored.
- gnt and rvalid in the same REQ cycle: only gnt is taken; rvalid must come in a later cycle (bus contract).
- Reset, including mid-access: state=IDLE, all outputs 0 immediately (async), load_data=0. Outstanding responses arriving after reset are ignored.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- When defined: a counter clears on entry to REQ and increments each cycle in REQ/RESP. When it reaches TIMEOUT_CYCLES -> DONE with bus_error pulsed for that cycle and load_data=0.
- When undefined: no counter, bus_error tied to 0, and the FSM waits indefinitely.

Test Plan:
- LD at addr 0x1000, gnt immediately, rvalid next cycle with rdata 0x1122334455667788 -> dmem_addr=0x1000, wstrb=0x00, stall for 3 cycles, load_data=0x1122334455667788 in DONE.
- LB at 0x1003, rdata 0x00000000_80000000 -> byte 0x80 loaded, load_data=0xFFFFFFFFFFFFFF80. LBU with the same stimulus -> load_data=0x80.
- SH at 0x2006, wdata 0xABCD -> dmem_we=1, wstrb=0xC0, dmem_wdata=0xABCD000000000000, completes on rvalid.
- LW at 0x3002 -> misaligned=1 for one cycle, dmem_req never asserted, stall for 1 cycle.
- gnt delayed 4 cycles -> req and address held constant throughout, stall extends by 4 cycles. Assert rst while in RESP -> req=0 and stall=0 at once; a later rvalid produces no DONE.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=16: no rvalid after gnt -> bus_error pulses exactly once, and the FSM returns to IDLE after DONE.
